// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT control path and its
// sample feeder.
//   FFT_N / FFT_LOG2N : frame length of the FFT core and its index width
//   FFT_DATA_W        : width of one real or imaginary component
//   fft_sample_t      : one complex sample {re, im}
//   feed_state_t      : drain state of the frame feeder
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_LOG2N  = 4;
  localparam int FFT_DATA_W = 16;

  // Fields are re/im because "real" is a reserved word.
  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } fft_sample_t;

  localparam fft_sample_t FFT_ZERO = '{re: 16'h0000, im: 16'h0000};

  typedef enum logic {
    FEED_IDLE = 1'b0,
    FEED_SEND = 1'b1
  } feed_state_t;

endpackage

// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two banks of FFT_N complex samples with per-bank full
// flag and last written index.
//   wr_en/wr_bank/wr_idx/wr_data : sample write into the fill bank
//   close_en                     : marks wr_bank full, stores wr_idx as last index
//   release_en/release_bank      : marks a drained bank empty
//   rd_bank/rd_idx               : combinational read address
//   rd_data/rd_last_idx          : sample and last valid index of rd_bank
//   full                         : per-bank full flags
module fft_pingpong_buf
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [FFT_LOG2N-1:0] wr_idx,
  input  fft_sample_t          wr_data,
  input  logic                 close_en,
  input  logic                 release_en,
  input  logic                 release_bank,
  input  logic                 rd_bank,
  input  logic [FFT_LOG2N-1:0] rd_idx,
  output fft_sample_t          rd_data,
  output logic [FFT_LOG2N-1:0] rd_last_idx,
  output logic [1:0]           full
);

  fft_sample_t          mem_r      [2][FFT_N];
  logic [FFT_LOG2N-1:0] last_idx_r [2];

  // Sample storage; contents are only ever read from a full bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Bank bookkeeping; close and release never address the same bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      full          <= 2'b00;
      last_idx_r[0] <= '0;
      last_idx_r[1] <= '0;
    end else begin
      if (close_en) begin
        full[wr_bank]       <= 1'b1;
        last_idx_r[wr_bank] <= wr_idx;
      end
      if (release_en) begin
        full[release_bank] <= 1'b0;
      end
    end
  end

  assign rd_data     = mem_r[rd_bank][rd_idx];
  assign rd_last_idx = last_idx_r[rd_bank];

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: collects upstream complex samples into a ping-pong
// frame buffer and bursts whole 16-sample frames to the FFT core.
//   clk, reset                       : clock, synchronous active-high reset
//   s_valid/s_ready/s_real/s_imag    : upstream valid/ready sample stream
//   s_last                           : ends a short frame (zero padded)
//   fft_push/fft_real/fft_imag       : sample toward the FFT core
//   fft_stall                        : core back-pressure, 1 = hold
//   frame_done                       : pulse after a frame's last transfer
//   frames_sent                      : wrapping count of delivered frames
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int ADDR_W = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  input  logic              s_last,
  output logic              fft_push,
  output logic [DATA_W-1:0] fft_real,
  output logic [DATA_W-1:0] fft_imag,
  input  logic              fft_stall,
  output logic              frame_done,
  output logic [15:0]       frames_sent
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic              wr_bank_r;
  logic [ADDR_W-1:0] wr_idx_r;
  logic              rd_bank_r;
  logic [ADDR_W-1:0] rd_idx_r;
  feed_state_t       state_r;

  logic              accept_s;
  logic              close_s;
  logic              release_s;
  logic [1:0]        full_s;
  logic [1:0]        full_next_s;
  logic              wr_bank_next_s;
  logic              load_bank_s;
  logic [ADDR_W-1:0] load_idx_s;
  fft_sample_t       rd_data_s;
  logic [ADDR_W-1:0] rd_last_idx_s;
  fft_sample_t       load_data_s;

  assign accept_s  = s_valid & s_ready;
  assign close_s   = accept_s & ((wr_idx_r == IDX_LAST) | s_last);
  assign release_s = fft_push & ~fft_stall & (rd_idx_r == IDX_LAST);

  fft_pingpong_buf u_buf (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (accept_s),
    .wr_bank      (wr_bank_r),
    .wr_idx       (wr_idx_r),
    .wr_data      ('{re: s_real, im: s_imag}),
    .close_en     (close_s),
    .release_en   (release_s),
    .release_bank (rd_bank_r),
    .rd_bank      (load_bank_s),
    .rd_idx       (load_idx_s),
    .rd_data      (rd_data_s),
    .rd_last_idx  (rd_last_idx_s),
    .full         (full_s)
  );

  // Flags and write bank as they will be after this edge, so the registered
  // s_ready already reflects a close and a release landing together.
  always_comb begin
    full_next_s    = (full_s | (close_s ? (wr_bank_r ? 2'b10 : 2'b01) : 2'b00))
                   & ~(release_s ? (rd_bank_r ? 2'b10 : 2'b01) : 2'b00);
    wr_bank_next_s = close_s ? ~wr_bank_r : wr_bank_r;
  end

  // Address of the entry to present after this edge: first entry of the read
  // bank when starting, first entry of the other bank after a frame's last
  // transfer, otherwise the next entry of the current bank.
  always_comb begin
    load_bank_s = rd_bank_r;
    load_idx_s  = '0;
    case (state_r)
      FEED_IDLE: begin
        load_bank_s = rd_bank_r;
        load_idx_s  = '0;
      end
      FEED_SEND: begin
        if (rd_idx_r == IDX_LAST) begin
          load_bank_s = ~rd_bank_r;
          load_idx_s  = '0;
        end else begin
          load_bank_s = rd_bank_r;
          load_idx_s  = rd_idx_r + IDX_ONE;
        end
      end
      default: begin
        load_bank_s = rd_bank_r;
        load_idx_s  = '0;
      end
    endcase
  end

  // Entries past the stored last index of a short frame go out as zero.
  always_comb begin
    if (load_idx_s > rd_last_idx_s) begin
      load_data_s = FFT_ZERO;
    end else begin
      load_data_s = rd_data_s;
    end
  end

  // Write indexer: fill position, fill bank and registered s_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_r <= 1'b0;
      wr_idx_r  <= '0;
      s_ready   <= 1'b0;
    end else begin
      if (close_s) begin
        wr_idx_r <= '0;
      end else if (accept_s) begin
        wr_idx_r <= wr_idx_r + IDX_ONE;
      end
      wr_bank_r <= wr_bank_next_s;
      s_ready   <= ~full_next_s[wr_bank_next_s];
    end
  end

  // Drain FSM with registered push/data; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= FEED_IDLE;
      rd_bank_r   <= 1'b0;
      rd_idx_r    <= '0;
      fft_push    <= 1'b0;
      fft_real    <= '0;
      fft_imag    <= '0;
      frame_done  <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        FEED_IDLE: begin
          if (full_s[rd_bank_r]) begin
            state_r  <= FEED_SEND;
            fft_push <= 1'b1;
            rd_idx_r <= '0;
            fft_real <= load_data_s.re;
            fft_imag <= load_data_s.im;
          end else begin
            fft_push <= 1'b0;
            fft_real <= '0;
            fft_imag <= '0;
          end
        end
        FEED_SEND: begin
          if (!fft_stall) begin
            if (rd_idx_r == IDX_LAST) begin
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
              rd_bank_r   <= ~rd_bank_r;
              rd_idx_r    <= '0;
              // Other bank already full: continue with no bubble.
              if (full_s[~rd_bank_r]) begin
                fft_push <= 1'b1;
                fft_real <= load_data_s.re;
                fft_imag <= load_data_s.im;
              end else begin
                state_r  <= FEED_IDLE;
                fft_push <= 1'b0;
                fft_real <= '0;
                fft_imag <= '0;
              end
            end else begin
              rd_idx_r <= rd_idx_r + IDX_ONE;
              fft_real <= load_data_s.re;
              fft_imag <= load_data_s.im;
            end
          end
        end
        default: begin
          state_r  <= FEED_IDLE;
          fft_push <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed self-checking bench for fft_frame_feeder.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_real;
  logic [15:0] s_imag;
  logic        s_last;
  logic        fft_push;
  logic [15:0] fft_real;
  logic [15:0] fft_imag;
  logic        fft_stall;
  logic        frame_done;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        stall_run;

  always #5 clk = ~clk;

  fft_frame_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .s_last      (s_last),
    .fft_push    (fft_push),
    .fft_real    (fft_real),
    .fft_imag    (fft_imag),
    .fft_stall   (fft_stall),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: records transfers and checks hold-under-stall.
  always @(negedge clk) begin
    cyc++;
    if (prev_stalled) begin
      check("hold_push", 32'(fft_push), 32'd1);
      check("hold_data", {fft_real, fft_imag}, prev_data);
    end
    if (fft_push && !fft_stall && !reset) begin
      got_q.push_back({fft_real, fft_imag});
      xfer_cyc.push_back(cyc);
    end
    if (frame_done) done_cnt++;
    prev_stalled = fft_push && fft_stall && !reset;
    prev_data    = {fft_real, fft_imag};
  end

  task automatic clear_log();
    got_q.delete();
    exp_q.delete();
    xfer_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
  endtask

  // Sends n samples re_base+k / im_base+k, s_last on index last_at (-1: none);
  // appends expectations, zero padded to 16 when pad is set.
  task automatic send_frame(input int n, input int last_at, input logic [15:0] re_base,
                            input logic [15:0] im_base, input bit pad);
    bit accepted;
    bit rdy;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_real  = re_base + 16'(k);
      s_imag  = im_base + 16'(k);
      s_last  = (k == last_at);
      exp_q.push_back({re_base + 16'(k), im_base + 16'(k)});
      accepted = 1'b0;
      for (int t = 0; t < 2000 && !accepted; t++) begin
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk);
        #1 accepted = rdy;
      end
      if (!accepted) begin
        check("handshake_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (pad) begin
      for (int k = n; k < 16; k++) exp_q.push_back(32'd0);
    end
  endtask

  task automatic wait_xfers(input int n);
    int t;
    for (t = 0; t < 3000 && got_q.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    if (got_q.size() < n) check("xfer_timeout", 32'(got_q.size()), 32'(n));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    logic [31:0] pat;
    int gaps;
    pat       = 32'b1011_0011_1000_1101_0110_0111_0001_1010;
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_real    = 16'd0;
    s_imag    = 16'd0;
    s_last    = 1'b0;
    fft_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_push", 32'(fft_push), 32'd0);
    check("rst_data", {fft_real, fft_imag}, 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("rdy_after_rst", 32'(s_ready), 32'd1);
    clear_log();

    // 1: one full frame, no stall; push one edge after the 16th handshake
    send_frame(16, -1, 16'd0, 16'd100, 1'b0);
    @(negedge clk);
    check("t1_lat_e0", 32'(fft_push), 32'd0);
    @(negedge clk);
    check("t1_lat_e1", 32'(fft_push), 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("t1_burst", 32'(fft_push), 32'd1);
    end
    @(negedge clk);
    check("t1_end", 32'(fft_push), 32'd0);
    @(posedge clk);
    #1;
    compare_frames("t1_data");
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_frames", 32'(frames_sent), 32'd1);

    // 2: stall toggling during drain
    clear_log();
    stall_run = 1'b1;
    fork
      begin
        send_frame(16, -1, 16'h1000, 16'h2000, 1'b0);
        wait_xfers(16);
        stall_run = 1'b0;
      end
      begin
        for (int i = 0; stall_run; i++) begin
          @(posedge clk);
          #1 fft_stall = pat[i % 32];
        end
        fft_stall = 1'b0;
      end
    join
    wait_xfers(16);
    compare_frames("t2_data");
    check("t2_frames", 32'(frames_sent), 32'd2);

    // 3: both banks fill under stall, then back-to-back drain
    clear_log();
    fft_stall = 1'b1;
    send_frame(32, -1, 16'h3000, 16'h4000, 1'b0);
    @(negedge clk);
    check("t3_ready_low", 32'(s_ready), 32'd0);
    check("t3_push_held", 32'(fft_push), 32'd1);
    @(posedge clk);
    #1;
    fork
      send_frame(16, -1, 16'h3020, 16'h4020, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 fft_stall = 1'b0;
      end
    join
    wait_xfers(48);
    compare_frames("t3_data");
    gaps = 0;
    for (int i = 1; i < 32 && i < xfer_cyc.size(); i++) begin
      if (xfer_cyc[i] != xfer_cyc[i-1] + 1) gaps++;
    end
    check("t3_no_gap", 32'(gaps), 32'd0);
    check("t3_ready_back", 32'(s_ready), 32'd1);
    check("t3_frames", 32'(frames_sent), 32'd5);

    // 4: short frame of 5 samples, padded with 11 zeros
    do_reset();
    send_frame(5, 4, 16'h00A0, 16'h00B0, 1'b1);
    wait_xfers(16);
    compare_frames("t4_data");
    check("t4_frames", 32'(frames_sent), 32'd1);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // 5: reset mid-drain after 7 transfers
    do_reset();
    send_frame(16, -1, 16'h5000, 16'h6000, 1'b0);
    for (int t = 0; t < 100 && got_q.size() < 7; t++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_push_rst", 32'(fft_push), 32'd0);
    check("t5_frames_rst", 32'(frames_sent), 32'd0);
    check("t5_ready_rst", 32'(s_ready), 32'd0);
    reset = 1'b0;
    clear_log();
    @(posedge clk);
    #1;
    check("t5_no_push", 32'(fft_push), 32'd0);
    check("t5_ready", 32'(s_ready), 32'd1);
    send_frame(16, -1, 16'h5100, 16'h6100, 1'b0);
    wait_xfers(16);
    compare_frames("t5_data");
    check("t5_frames", 32'(frames_sent), 32'd1);

    // 6: frames_sent wraps; s_last on the 16th sample is a normal frame
    clear_log();
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    check("t6_preload", 32'(frames_sent), 32'h0000_FFFF);
    release dut.frames_sent;
    @(posedge clk);
    #1;
    send_frame(16, 15, 16'h7000, 16'h7100, 1'b0);
    wait_xfers(16);
    compare_frames("t6_data");
    check("t6_wrap", 32'(frames_sent), 32'd0);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
